// File: rtl/reg_access_master_if.sv
// Requester command/response handshake plus the register-block strobe bus.
interface reg_access_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_count;
    logic [31:0] rx_data;
    logic        reg_num_le;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] tx_data;
    logic        illegal_reg_num;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, tx_data, illegal_reg_num,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, rx_data, reg_num_le, wr_en,
               rd_en
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, tx_data, illegal_reg_num,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_count, rx_data, reg_num_le, wr_en,
               rd_en
    );
endinterface

// File: rtl/reg_access_master.sv
// Turns single register transactions into select/check/write-or-read strobe sequences,
// caching the last legal register number so repeat accesses skip the select phase.
module reg_access_master #(
    parameter int unsigned RD_LAT   = 1,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    reg_access_master_if.master bus
);
    localparam int unsigned     CntW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CntW-1:0] LatLast = CntW'(RD_LAT - 1);

    typedef enum logic [2:0] {StIdle, StSel, StChk, StWr, StRd, StRwait, StRsp} state_e;

    state_e          state;
    logic            hold_write;
    logic [31:0]     hold_addr;
    logic [31:0]     hold_wdata;
    logic            cache_valid;
    logic [31:0]     cache_addr;
    logic [CntW-1:0] lat_cnt;
    logic            cache_hit;

    assign cache_hit = CACHE_EN && cache_valid && (bus.cmd_addr == cache_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StIdle;
            hold_write     <= 1'b0;
            hold_addr      <= '0;
            hold_wdata     <= '0;
            cache_valid    <= 1'b0;
            cache_addr     <= '0;
            lat_cnt        <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
            bus.err_count  <= '0;
            bus.rx_data    <= '0;
            bus.reg_num_le <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.rd_en      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; rx_data idles at zero between them.
            bus.reg_num_le <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.rx_data    <= '0;
            unique case (state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        hold_write    <= bus.cmd_write;
                        hold_addr     <= bus.cmd_addr;
                        hold_wdata    <= bus.cmd_wdata;
                        bus.cmd_ready <= 1'b0;
                        if (cache_hit && bus.cmd_write) begin
                            state       <= StWr;
                            bus.wr_en   <= 1'b1;
                            bus.rx_data <= bus.cmd_wdata;
                        end else if (cache_hit) begin
                            state     <= StRd;
                            bus.rd_en <= 1'b1;
                        end else begin
                            state          <= StSel;
                            bus.reg_num_le <= 1'b1;
                            bus.rx_data    <= bus.cmd_addr;
                        end
                    end
                end
                StSel: state <= StChk;
                StChk: begin
                    if (bus.illegal_reg_num) begin
                        cache_valid   <= 1'b0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.rsp_valid <= 1'b1;
                        state         <= StRsp;
                    end else begin
                        cache_valid <= 1'b1;
                        cache_addr  <= hold_addr;
                        if (hold_write) begin
                            state       <= StWr;
                            bus.wr_en   <= 1'b1;
                            bus.rx_data <= hold_wdata;
                        end else begin
                            state     <= StRd;
                            bus.rd_en <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    state         <= StRsp;
                end
                StRd: begin
                    lat_cnt <= '0;
                    state   <= StRwait;
                end
                StRwait: begin
                    if (lat_cnt == LatLast) begin
                        bus.rsp_rdata <= bus.tx_data;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= StRsp;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                StRsp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= StIdle;
                        if (bus.rsp_err && bus.err_count != 16'hFFFF) begin
                            bus.err_count <= bus.err_count + 16'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_access_master.sv
// Randomized bench: a transaction-level model predicts strobe timing and responses,
// and one compare process checks every DUT output each cycle.
module tb_reg_access_master;
    localparam int unsigned RdLat = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    reg_access_master_if bus();

    reg_access_master #(
        .RD_LAT   (RdLat),
        .CACHE_EN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 1) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Register block stand-in: latched number, illegal flag, registered readback.
    logic [31:0] blk_regs [16];
    logic [31:0] blk_num = '0;
    bit          blk_loaded = 1'b0;

    always @(posedge clk) begin
        if (!blk_loaded) begin
            for (int i = 0; i < 16; i++) blk_regs[i] <= init_val(i);
            blk_loaded <= 1'b1;
        end
        if (bus.reg_num_le) blk_num <= bus.rx_data;
        if (bus.wr_en && blk_num < 32'd16) blk_regs[blk_num[3:0]] <= bus.rx_data;
        if (bus.rd_en) bus.tx_data <= (blk_num < 32'd16) ? blk_regs[blk_num[3:0]] : 32'hBAD0_BAD0;
    end

    assign bus.illegal_reg_num = (blk_num > 32'd15);

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tmo_count = 0;
    int tmo_seen = 0;

    bit          pin_en = 1'b0;
    logic [31:0] pin_rdata = '0;
    bit          pin_err = 1'b0;
    int          pin_lat = 0;
    int          pin_nle = 0;
    int          pin_errcnt = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state
    bit          m_seen_rst = 1'b0;
    bit          m_post_rst = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_cache_v = 1'b0;
    logic [31:0] m_cache_a = '0;
    logic [31:0] m_regs [16];
    logic [15:0] m_errcnt = '0;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_is_wr, m_err;
    int          m_c0, m_le_k, m_op_k, m_rsp_k, m_first_k, m_nle;

    initial begin : compare
        int k;
        bit e_le, e_wr, e_rd, e_rv, e_cr;
        logic [31:0] e_rx;
        for (int i = 0; i < 16; i++) m_regs[i] = init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            e_le = 0; e_wr = 0; e_rd = 0; e_rv = 0; e_cr = 1; e_rx = '0; k = 0;
            if (m_busy) begin
                k    = cyc - m_c0;
                e_le = (k == m_le_k);
                e_wr = m_is_wr && (k == m_op_k);
                e_rd = !m_is_wr && (k == m_op_k);
                e_rx = e_le ? m_addr : (e_wr ? m_wdata : 32'd0);
                e_rv = (k >= m_rsp_k);
                e_cr = 1'b0;
            end
            if (m_seen_rst) begin
                chk("reg_num_le", 32'(bus.reg_num_le), 32'(e_le));
                chk("wr_en", 32'(bus.wr_en), 32'(e_wr));
                chk("rd_en", 32'(bus.rd_en), 32'(e_rd));
                chk("rx_data", bus.rx_data, e_rx);
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_cr));
                chk("err_count", 32'(bus.err_count), 32'(m_errcnt));
                if (e_rv) begin
                    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
                end
                if (m_post_rst) begin
                    chk("reset_rdata", bus.rsp_rdata, 32'd0);
                    chk("reset_err", 32'(bus.rsp_err), 32'd0);
                end
                if (m_busy && bus.reg_num_le) m_nle++;
                if (m_busy && bus.rsp_valid && m_first_k < 0) m_first_k = k;
            end
            if (tmo_count != tmo_seen) begin
                chk("driver_timeout", 32'(tmo_count), 32'(tmo_seen));
                tmo_seen = tmo_count;
            end
            m_post_rst = 1'b0;
            if (reset) begin
                m_seen_rst = 1'b1;
                m_post_rst = 1'b1;
                m_busy     = 1'b0;
                m_cache_v  = 1'b0;
                m_errcnt   = '0;
            end else if (m_seen_rst && m_busy) begin
                if (e_wr) m_regs[m_addr[3:0]] = m_wdata;
                if (e_rv && bus.rsp_ready) begin
                    if (m_err && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
                    if (pin_en) begin
                        chk("pin_rdata", bus.rsp_rdata, pin_rdata);
                        chk("pin_err", 32'(bus.rsp_err), 32'(pin_err));
                        chk("pin_lat_dut", 32'(m_first_k), 32'(pin_lat));
                        chk("pin_lat_model", 32'(m_rsp_k), 32'(pin_lat));
                        chk("pin_nle", 32'(m_nle), 32'(pin_nle));
                        if (pin_errcnt >= 0) chk("pin_errcnt", 32'(m_errcnt), 32'(pin_errcnt));
                    end
                    m_busy = 1'b0;
                end
            end else if (m_seen_rst && bus.cmd_valid) begin
                m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata; m_is_wr = bus.cmd_write;
                m_c0 = cyc; m_first_k = -1; m_nle = 0; m_err = 1'b0; m_rdata = '0;
                if (m_cache_v && m_addr == m_cache_a) begin
                    m_le_k = -1; m_op_k = 1;
                end else if (m_addr > 32'd15) begin
                    m_le_k = 1; m_op_k = -1; m_err = 1'b1; m_cache_v = 1'b0;
                end else begin
                    m_le_k = 1; m_op_k = 3; m_cache_v = 1'b1; m_cache_a = m_addr;
                end
                if (m_err) m_rsp_k = 3;
                else if (m_is_wr) m_rsp_k = m_op_k + 1;
                else begin
                    m_rsp_k = m_op_k + 1 + int'(RdLat);
                    m_rdata = m_regs[m_addr[3:0]];
                end
                m_busy = 1'b1;
            end
        end
    end

    task automatic start_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                             output bit acc);
        int cnt = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
        bus.rsp_ready = 1'b0;
        acc = 1'b0;
        while (!acc && cnt < 20) begin
            @(negedge clk);
            if (bus.cmd_ready) acc = 1'b1;
            else begin @(posedge clk); #1; end
            cnt++;
        end
        if (!acc) begin
            tmo_count++;
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the command bus so only the captured copy can be used.
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom);
        bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
    endtask

    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
        bit acc, done;
        int seen, cnt;
        start_cmd(w, a, d, acc);
        if (!acc) return;
        seen = 0; done = 1'b0; cnt = 0;
        while (!done && cnt < 80) begin
            bus.rsp_ready = (seen >= hold);
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (bus.rsp_ready) done = 1'b1;
                else seen++;
            end
            cnt++;
            if (!done) begin @(posedge clk); #1; end
        end
        if (!done) tmo_count++;
    endtask

    task automatic txn_rst(input bit w, input logic [31:0] a, input logic [31:0] d, input int off);
        bit acc;
        start_cmd(w, a, d, acc);
        if (!acc) return;
        bus.rsp_ready = 1'b0;
        repeat (off - 1) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_pin(input logic [31:0] rd, input bit err, input int lat, input int nle,
                           input int ecnt);
        pin_en = 1'b1; pin_rdata = rd; pin_err = err; pin_lat = lat; pin_nle = nle;
        pin_errcnt = ecnt;
    endtask

    initial begin : driver
        logic [31:0] a, last_a;
        bit w;
        int r;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        set_pin(32'h0, 0, 4, 1, 0);          txn(1'b1, 32'd2, 32'h0000_0FFF, 0);
        set_pin(32'h0000_0FFF, 0, 3, 0, 0);  txn(1'b0, 32'd2, 32'h0, 0);
        set_pin(32'h0, 1, 3, 1, 1);          txn(1'b0, 32'h10, 32'h0, 0);
        set_pin(32'h0, 1, 3, 1, 2);          txn(1'b0, 32'h10, 32'h0, 0);
        set_pin(32'hDEAD_BEEF, 0, 5, 1, 2);  txn(1'b0, 32'd1, 32'h0, 0);
        set_pin(32'hDEAD_BEEF, 0, 3, 0, 2);  txn(1'b0, 32'd1, 32'h0, 10);
        for (int i = 0; i < 4; i++) begin
            set_pin(32'h0, 0, 4, 1, 2);
            txn(1'b1, (i % 2 == 0) ? 32'd3 : 32'd4, 32'hAAAA_0000 + 32'(i), 0);
        end
        pin_en = 1'b0;
        txn_rst(1'b0, 32'd5, 32'h0, 4);
        set_pin(32'hC0DE_0005, 0, 5, 1, 0);  txn(1'b0, 32'd5, 32'h0, 0);
        pin_en = 1'b0;

        last_a = 32'd5;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            w = 1'($urandom);
            if (r < 30) a = last_a;
            else if (r < 85) a = $urandom_range(0, 15);
            else if (r < 93) a = $urandom_range(16, 40);
            else a = $urandom;
            if ($urandom_range(0, 19) == 0) txn_rst(w, a, $urandom, $urandom_range(1, 5));
            else txn(w, a, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
            last_a = a;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
